// File: rtl/datapath_pkg.sv
// Shared execute-stage datapath types: word/matrix-index widths, the matrix
// memory op encoding, the packed result bundle reported by the matrix
// load/store unit, and that unit's FSM state encoding.
package datapath_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  matbits_t;

   typedef enum logic [1:0] {
      matrix_na = 2'd0,
      M_LOAD    = 2'd1,
      M_STORE   = 2'd2
   } matrix_mem_t;

   typedef struct packed {
      logic        done;
      matrix_mem_t ls_out;
      matbits_t    rd_out;
      word_t       address;
      word_t       stride_out;
   } matrix_ls_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } mls_state_e;

endpackage

// File: rtl/matrix_ls_agen.sv
// Combinational scratchpad address/stride generator for the matrix load/store
// unit. The address is base + immediate with the carry out dropped; the
// misalignment flag reports non-zero low bits in either address or stride.
module matrix_ls_agen #(
   parameter int ADDR_W     = 32,
   parameter int ALIGN_BITS = 2
) (
   input  logic [ADDR_W-1:0] rdat1_i,
   input  logic [ADDR_W-1:0] rdat2_i,
   input  logic [ADDR_W-1:0] imm_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ADDR_W-1:0] stride_o,
   output logic              misalign_o
);

   assign addr_o     = rdat1_i + imm_i;
   assign stride_o   = rdat2_i;
   assign misalign_o = (|addr_o[ALIGN_BITS-1:0]) | (|rdat2_i[ALIGN_BITS-1:0]);

endmodule

// File: rtl/matrix_ls_fu.sv
// Matrix load/store functional unit. Latches one op from issue, computes its
// scratchpad address, handshakes a request (stores wait until they are no
// longer speculative), waits for completion and pulses done. Ops squashed by
// a branch miss retire silently; an already-sent request is drained first.
// Optional build macro MLS_ALIGN_CHECK_EN: misaligned address/stride skips the
// scratchpad and pulses fault together with done on the cycle after issue.
module matrix_ls_fu
   import datapath_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int MAT_W      = 4,
   parameter int ALIGN_BITS = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              issue_en,
   input  matrix_mem_t       issue_ls,
   input  logic [MAT_W-1:0]  issue_md,
   input  logic [ADDR_W-1:0] issue_rdat1,
   input  logic [ADDR_W-1:0] issue_rdat2,
   input  logic [ADDR_W-1:0] issue_imm,
   input  logic              issue_spec,
   input  logic              br_resolved,
   input  logic              br_miss,
   input  logic              sp_ready,
   input  logic              sp_done,
   output logic              sp_req,
   output matrix_ls_t        mls_out,
   output logic              busy,
   output logic              fault
);

   mls_state_e        state_q, state_d;
   matrix_mem_t       ls_q, ls_d;
   logic [MAT_W-1:0]  md_q, md_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic              spec_q, spec_d;
   logic              done_q, done_d;

   logic [ADDR_W-1:0] agen_addr, agen_stride;
   logic              agen_misalign;
   logic              accept, squash, handshake;
   logic              fault_go, fault_pulse;

   matrix_ls_agen #(
      .ADDR_W     (ADDR_W),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_agen (
      .rdat1_i    (issue_rdat1),
      .rdat2_i    (issue_rdat2),
      .imm_i      (issue_imm),
      .addr_o     (agen_addr),
      .stride_o   (agen_stride),
      .misalign_o (agen_misalign)
   );

   // Only real load/store encodings start an op, and only while idle.
   assign accept    = issue_en && (state_q == IDLE) &&
                      ((issue_ls == M_LOAD) || (issue_ls == M_STORE));
   assign squash    = br_miss && spec_q;
   assign handshake = sp_req && sp_ready;

`ifdef MLS_ALIGN_CHECK_EN
   logic pend_q;

   assign fault_go    = accept && agen_misalign;
   // A faulting op never enters REQ; it only pulses on the following cycle
   // unless a branch miss squashes it in that cycle.
   assign fault_pulse = pend_q && !squash;

   // One-cycle marker for a latched misaligned op.
   always_ff @(posedge CLK) begin
      if (RST) pend_q <= 1'b0;
      else     pend_q <= fault_go;
   end
`else
   logic unused_misalign;

   assign fault_go        = 1'b0;
   assign fault_pulse     = 1'b0;
   assign unused_misalign = agen_misalign;
`endif

   // State and latched op fields; everything clears on reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         ls_q     <= matrix_na;
         md_q     <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         spec_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ls_q     <= ls_d;
         md_q     <= md_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         spec_q   <= spec_d;
         done_q   <= done_d;
      end
   end

   // Next state: latch on issue, request/wait/drain, and squash handling.
   always_comb begin
      state_d  = state_q;
      ls_d     = ls_q;
      md_d     = md_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      spec_d   = spec_q && !br_resolved;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            spec_d = 1'b0;
            if (accept) begin
               spec_d = issue_spec;
               if (!fault_go) begin
                  state_d  = REQ;
                  ls_d     = issue_ls;
                  md_d     = issue_md;
                  addr_d   = agen_addr;
                  stride_d = agen_stride;
               end
            end
         end
         REQ: begin
            if (handshake) begin
               // A request already handed over must be drained on a squash.
               if (squash)       state_d = sp_done ? IDLE : DRAIN;
               else if (sp_done) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else          state_d = WAIT;
            end else if (squash) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (sp_done) begin
               state_d = IDLE;
               done_d  = !squash;
            end else if (squash) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (sp_done) state_d = IDLE;
         end
      endcase
      // Reported fields read zero whenever the unit is idle.
      if (state_d == IDLE) begin
         ls_d     = matrix_na;
         md_d     = '0;
         addr_d   = '0;
         stride_d = '0;
         if (!fault_go) spec_d = 1'b0;
      end
   end

   // Outputs: stores hold off the request while still speculative.
   always_comb begin
      busy               = (state_q != IDLE);
      sp_req             = (state_q == REQ) && ((ls_q == M_LOAD) || !spec_q);
      fault              = fault_pulse;
      mls_out.done       = done_q || fault_pulse;
      mls_out.ls_out     = ls_q;
      mls_out.rd_out     = md_q;
      mls_out.address    = addr_q;
      mls_out.stride_out = stride_q;
   end

endmodule
